pin_link_host: RTL

// Host-side end of the 12-bit chip pin link. Used in the FPGA/bench harness that drives
// the cache-system chip. Serializes one cache request at a time into byte beats on the

---
 rtl/pin_link_host.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pin_link_host.sv
// pin_link_host: host end of the 12-bit chip pin link; serializes one request into
// byte beats and collects the 3-beat response frame, with timeout and error counting.
module pin_link_host #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int ERR_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_core,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [1:0]       resp_core,
    output logic [15:0]      resp_rdata,
    output logic [ERR_W-1:0] err_count,
    output logic [11:0]      chip_in,
    input  logic [11:0]      chip_out
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    typedef enum logic [2:0] {IDLE, SEND, WAIT, RESP, DONE} state_t;
    state_t           state_q;
    logic [1:0]       op_q, core_q, resp_status_q, resp_core_q;
    logic [15:0]      addr_q, wdata_q, resp_rdata_q;
    logic [2:0]       beat_q, beat_d, last_beat;
    logic [TW-1:0]    timer_q;
    logic             rcnt_q, req_ready_q, resp_valid_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic [11:0]      chip_in_q;
    logic [7:0]       next_byte;
    logic             in_vld, in_sof, consumed, frame_err;
    always_comb begin
        in_vld    = chip_out[11];
        in_sof    = chip_out[10];
        consumed  = chip_in_q[11] && !chip_out[9];
        last_beat = (op_q == 2'b01) ? 3'd4 : 3'd2;
        beat_d    = beat_q + 3'd1;
        next_byte = (beat_d == 3'd1) ? addr_q[15:8] :
                    (beat_d == 3'd2) ? addr_q[7:0] :
                    (beat_d == 3'd3) ? wdata_q[15:8] : wdata_q[7:0];
        // Any vld beat not expected by the current state is a framing error.
        frame_err = in_vld && ((state_q == IDLE) || (state_q == SEND) || (state_q == DONE) ||
                               (state_q == WAIT && !in_sof) || (state_q == RESP && in_sof));
        err_d     = err_q + ERR_W'(frame_err && !(&err_q));
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            core_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            beat_q        <= '0;
            timer_q       <= '0;
            rcnt_q        <= 1'b0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= '0;
            resp_core_q   <= '0;
            resp_rdata_q  <= '0;
            err_q         <= '0;
            chip_in_q     <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        core_q      <= req_core;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        beat_q      <= '0;
                        chip_in_q   <= {4'b1100, req_op, req_core, 4'h0};
                        req_ready_q <= 1'b0;
                        state_q     <= SEND;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (consumed && beat_q == last_beat) begin
                        chip_in_q <= '0;
                        timer_q   <= '0;
                        state_q   <= WAIT;
                    end else if (consumed) begin
                        beat_q    <= beat_d;
                        chip_in_q <= {4'b1000, next_byte};
                    end
                end
                WAIT: begin
                    if (in_vld && in_sof) begin
                        resp_status_q <= chip_out[7:6];
                        resp_core_q   <= chip_out[5:4];
                        rcnt_q        <= 1'b0;
                        state_q       <= RESP;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        resp_status_q <= 2'b11;
                        resp_core_q   <= core_q;
                        resp_rdata_q  <= '0;
                        resp_valid_q  <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (in_vld && in_sof) begin
                        resp_status_q <= chip_out[7:6];
                        resp_core_q   <= chip_out[5:4];
                        rcnt_q        <= 1'b0;
                    end else if (in_vld && !rcnt_q) begin
                        resp_rdata_q[15:8] <= chip_out[7:0];
                        rcnt_q             <= 1'b1;
                    end else if (in_vld) begin
                        resp_rdata_q[7:0] <= chip_out[7:0];
                        resp_valid_q      <= 1'b1;
                        state_q           <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign resp_core   = resp_core_q;
    assign resp_rdata  = resp_rdata_q;
    assign err_count   = err_q;
    assign chip_in     = chip_in_q;
endmodule
